measurement_sequencer: RTL

MEASUREMENT_SEQUENCER -- requirements
Module: measurement_sequencer

---
 rtl/measurement_sequencer_pkg.sv | 29 ++
 rtl/measurement_sequencer_fifo.sv | 48 ++++
 rtl/measurement_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/measurement_sequencer_pkg.sv
// rtl/measurement_sequencer_pkg.sv - shared encodings and helpers for the measurement sequencer
package measurement_sequencer_pkg;

    localparam logic [1:0] MEAS_SEL_16      = 2'd0;
    localparam logic [1:0] MEAS_SEL_32      = 2'd1;
    localparam logic [1:0] MEAS_SEL_48      = 2'd2;
    localparam logic [1:0] MEAS_SEL_ILLEGAL = 2'd3;

    localparam int MEASUREMENT_NUM = 16;
    localparam int INDEX_W         = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Highest measurement index (N-1) for a legal selection; illegal codes are
    // filtered before this is used.
    function automatic logic [INDEX_W-1:0] meas_last_index(input logic [1:0] sel);
        case (sel)
            MEAS_SEL_32: return 6'd31;
            MEAS_SEL_48: return 6'd47;
            default:     return 6'd15;
        endcase
    endfunction

endpackage

// File: rtl/measurement_sequencer_fifo.sv
// rtl/measurement_sequencer_fifo.sv - two-entry skid FIFO holding ROM words and their tags
module meas_skid_fifo #(
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/measurement_sequencer.sv
// rtl/measurement_sequencer.sv - walks ROM blocks and streams tagged measurement words
module measurement_sequencer
    import measurement_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int BLK_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_meas_sel,
    input  logic [BLK_W-1:0]  cfg_blocks,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [5:0]        m_index,
    output logic [BLK_W-1:0]  m_block,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int TAG_W = DATA_W + INDEX_W + BLK_W + 1;

    seq_state_e         state;
    logic [INDEX_W-1:0] n_last_q;
    logic [BLK_W-1:0]   blocks_last_q;
    logic [INDEX_W-1:0] index_q;
    logic [BLK_W-1:0]   block_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    logic               rd_valid_q;
    logic [INDEX_W-1:0] rd_index_q;
    logic [BLK_W-1:0]   rd_block_q;
    logic               rd_last_q;

    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         occ;
    logic [1:0]         occ_after_pop;
    logic               credit_ok;
    logic               issue_last;
    logic               head_last;
    logic [TAG_W-1:0]   push_data;
    logic [TAG_W-1:0]   head_data;

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // A word leaving this cycle frees its slot at once, which is what lets a
    // two-entry FIFO sustain one word per cycle against the two-cycle ROM loop.
    assign occ           = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occ_after_pop = occ - {1'b0, pop};
    assign credit_ok     = ({1'b0, occ_after_pop} + {2'b00, rd_valid_q}) < 3'd2;

    assign rom_en     = (state == ST_FETCH) && credit_ok;
    assign rom_addr   = addr_q;
    assign issue_last = (index_q == n_last_q) && (block_q == blocks_last_q);

    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    assign push_data = {rom_data, rd_index_q, rd_block_q, rd_last_q};
    assign {m_data, m_index, m_block, head_last} = head_data;
    assign m_last    = head_last && m_valid;

    // Run control: configuration latch, index/block/address counters and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            n_last_q      <= INDEX_W'(MEASUREMENT_NUM - 1);
            blocks_last_q <= '0;
            index_q       <= '0;
            block_q       <= '0;
            addr_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if ((cfg_meas_sel == MEAS_SEL_ILLEGAL) || (cfg_blocks == '0)) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            n_last_q      <= meas_last_index(cfg_meas_sel);
                            blocks_last_q <= cfg_blocks - BLK_W'(1);
                            index_q       <= '0;
                            block_q       <= '0;
                            addr_q        <= '0;
                            busy_q        <= 1'b1;
                            state         <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (rom_en) begin
                        if (issue_last) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (index_q == n_last_q) begin
                                index_q <= '0;
                                block_q <= block_q + BLK_W'(1);
                            end else begin
                                index_q <= index_q + INDEX_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !rd_valid_q) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tags travel alongside each read so they meet the ROM data one cycle later;
    // clearing rd_valid on reset drops any word still returning from the ROM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_index_q <= '0;
            rd_block_q <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rom_en;
            if (rom_en) begin
                rd_index_q <= index_q;
                rd_block_q <= block_q;
                rd_last_q  <= (index_q == n_last_q);
            end
        end
    end

    meas_skid_fifo #(
        .WIDTH (TAG_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_valid_q),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
